// File: rtl/amm_arb_pkg.sv
// Shared types and helpers for the Avalon-MM round-robin arbiter.
package amm_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width needed to hold an index in [0, n-1]; never less than one bit.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// Avalon-MM bus bundle with master and slave views.
interface avalon_mm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/amm_arb_fifo.sv
// Pending-read ID queue: remembers which master owns each outstanding read.
module amm_arb_fifo
  import amm_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = id_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rptr_q];

  // Next pointers, count and storage; push into a full queue or pop from an empty one is dropped.
  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by reset so pending IDs are discarded.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only slots behind a valid count are ever read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/amm_arbiter.sv
// Round-robin arbiter connecting several Avalon-MM masters to one slave,
// routing read responses back through a queue of pending master IDs.
module amm_arbiter
  import amm_arb_pkg::*;
#(
  parameter int MST_CNT  = 2,
  parameter int MAX_PEND = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  avalon_mm_if.slave  mst_mem_if [0:MST_CNT-1],
  avalon_mm_if.master slv_mem_if
);
  localparam int ID_W = id_width(MST_CNT);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0]  mst_addr  [MST_CNT];
  logic [DATA_W-1:0]  mst_wdata [MST_CNT];
  logic [BE_W-1:0]    mst_be    [MST_CNT];
  logic [MST_CNT-1:0] mst_read, mst_write, mst_wait, mst_rdv;

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d, last_id_q, last_id_d;
  logic [ID_W-1:0] rr_id, cand;
  logic            found;
  logic            gnt_read, gnt_write, stall;
  logic            slv_read, slv_write;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0] fifo_head;

  for (genvar g = 0; g < MST_CNT; g++) begin : g_mst
    assign mst_addr[g]  = mst_mem_if[g].address;
    assign mst_wdata[g] = mst_mem_if[g].writedata;
    assign mst_be[g]    = mst_mem_if[g].byteenable;
    assign mst_read[g]  = mst_mem_if[g].read;
    assign mst_write[g] = mst_mem_if[g].write;
    assign mst_mem_if[g].waitrequest   = mst_wait[g];
    assign mst_mem_if[g].readdatavalid = mst_rdv[g];
    assign mst_mem_if[g].readdata      = slv_mem_if.readdata;
  end

  assign slv_mem_if.address    = mst_addr[grant_id_q];
  assign slv_mem_if.writedata  = mst_wdata[grant_id_q];
  assign slv_mem_if.byteenable = mst_be[grant_id_q];
  assign slv_mem_if.read       = slv_read;
  assign slv_mem_if.write      = slv_write;

  // Round-robin pick: first requester after the last served master, wrapping around.
  always_comb begin
    rr_id = last_id_q;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= MST_CNT; i++) begin
      cand = ID_W'((int'(last_id_q) + i) % MST_CNT);
      if (!found && (mst_read[cand] || mst_write[cand])) begin
        rr_id = cand;
        found = 1'b1;
      end
    end
  end

  // Grant FSM: pass the granted master through, hold reads while the ID queue is full.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    gnt_read   = mst_read[grant_id_q];
    gnt_write  = mst_write[grant_id_q];
    stall      = 1'b0;
    slv_read   = 1'b0;
    slv_write  = 1'b0;
    fifo_push  = 1'b0;
    mst_wait   = '1;
    case (state_q)
      IDLE: begin
        if (|(mst_read | mst_write)) begin
          grant_id_d = rr_id;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!(gnt_read || gnt_write)) begin
          state_d = IDLE;
        end else begin
          stall     = gnt_read && fifo_full;
          slv_read  = gnt_read && !fifo_full;
          slv_write = gnt_write && !stall;
          mst_wait[grant_id_q] = stall || slv_mem_if.waitrequest;
          if ((slv_read || slv_write) && !slv_mem_if.waitrequest) begin
            fifo_push = slv_read;
            last_id_d = grant_id_q;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Steer each read response to the master at the queue head; stray responses are dropped.
  always_comb begin
    fifo_pop = slv_mem_if.readdatavalid && !fifo_empty;
    mst_rdv  = '0;
    if (fifo_pop) begin
      mst_rdv[fifo_head] = 1'b1;
    end
  end

  // State and arbitration registers; last_id starts at the top so master 0 wins first.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(MST_CNT - 1);
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
    end
  end

  amm_arb_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_PEND)
  ) u_pend_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (grant_id_q),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_amm_arbiter.sv
// Directed bench for amm_arbiter with two masters and an 8-deep pending queue.
module tb_amm_arbiter;

  typedef struct {
    logic        rst_n;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        s_wait;
    logic        s_rdv;
    logic [15:0] s_rdata;
    logic        exp_sr;
    logic        exp_sw;
    int          exp_gnt;
    logic [1:0]  exp_mwait;
    logic [1:0]  exp_mrdv;
  } vec_t;

  localparam int NV = 19;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_addr  [2];
  logic [15:0] m_wdata [2];
  logic [1:0]  m_be    [2];
  logic [1:0]  m_rd, m_wr;
  logic [1:0]  m_wait, m_rdv;
  logic [15:0] m_rdata [2];
  logic        s_wait, s_rdv;
  logic [15:0] s_rdata;
  logic        s_read, s_write;
  logic [31:0] s_addr;
  logic [15:0] s_wdata;
  logic [1:0]  s_be;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs [NV];

  avalon_mm_if #(.ADDR_W(32), .DATA_W(16)) mst_if [0:1] ();
  avalon_mm_if #(.ADDR_W(32), .DATA_W(16)) slv_if ();

  for (genvar g = 0; g < 2; g++) begin : g_if
    assign mst_if[g].address    = m_addr[g];
    assign mst_if[g].writedata  = m_wdata[g];
    assign mst_if[g].byteenable = m_be[g];
    assign mst_if[g].read       = m_rd[g];
    assign mst_if[g].write      = m_wr[g];
    assign m_wait[g]  = mst_if[g].waitrequest;
    assign m_rdv[g]   = mst_if[g].readdatavalid;
    assign m_rdata[g] = mst_if[g].readdata;
  end

  assign slv_if.waitrequest   = s_wait;
  assign slv_if.readdatavalid = s_rdv;
  assign slv_if.readdata      = s_rdata;
  assign s_read  = slv_if.read;
  assign s_write = slv_if.write;
  assign s_addr  = slv_if.address;
  assign s_wdata = slv_if.writedata;
  assign s_be    = slv_if.byteenable;

  amm_arbiter #(
    .MST_CNT  (2),
    .MAX_PEND (8),
    .ADDR_W   (32),
    .DATA_W   (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .mst_mem_if (mst_if),
    .slv_mem_if (slv_if)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic [1:0] rd, input logic [1:0] wr,
                              input logic sw, input logic rdv, input logic [15:0] rdata,
                              input logic e_sr, input logic e_sw, input int e_gnt,
                              input logic [1:0] e_wait, input logic [1:0] e_rdv);
    vec_t v;
    v.rst_n = rst;   v.rd = rd;       v.wr = wr;
    v.s_wait = sw;   v.s_rdv = rdv;   v.s_rdata = rdata;
    v.exp_sr = e_sr; v.exp_sw = e_sw; v.exp_gnt = e_gnt;
    v.exp_mwait = e_wait; v.exp_mrdv = e_rdv;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_n   = v.rst_n;
    m_rd    = v.rd;
    m_wr    = v.wr;
    s_wait  = v.s_wait;
    s_rdv   = v.s_rdv;
    s_rdata = v.s_rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Safety net in case the DUT wedges a handshake loop.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accepted;

    // Row fields: rst, rd, wr, s_wait, s_rdv, s_rdata | exp s_read, s_write, grant, mst wait {m1,m0}, mst rdv {m1,m0}
    vecs[0]  = mk(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[1]  = mk(1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[2]  = mk(1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1,  0, 2'b10, 2'b00);
    vecs[3]  = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[4]  = mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[5]  = mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0,  1, 2'b01, 2'b00);
    vecs[6]  = mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[7]  = mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b0,  0, 2'b10, 2'b10);
    vecs[8]  = mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[9]  = mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 16'hA002, 1'b1, 1'b0,  1, 2'b01, 2'b01);
    vecs[10] = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[11] = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 16'hA003, 1'b0, 1'b0, -1, 2'b11, 2'b10);
    vecs[12] = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 16'hA004, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[13] = mk(1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[14] = mk(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[15] = mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[16] = mk(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0,  0, 2'b10, 2'b00);
    vecs[17] = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, -1, 2'b11, 2'b00);
    vecs[18] = mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 16'h5A5A, 1'b0, 1'b0, -1, 2'b11, 2'b01);

    m_addr[0] = 32'h0000_0040; m_wdata[0] = 16'h1234; m_be[0] = 2'b11;
    m_addr[1] = 32'h0000_0080; m_wdata[1] = 16'hBEEF; m_be[1] = 2'b01;
    rst_n = 1'b0; m_rd = '0; m_wr = '0; s_wait = 1'b0; s_rdv = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("row%0d s_read", i), 32'(s_read), 32'(vecs[i].exp_sr));
      checkOutput($sformatf("row%0d s_write", i), 32'(s_write), 32'(vecs[i].exp_sw));
      checkOutput($sformatf("row%0d mst_wait", i), 32'(m_wait), 32'(vecs[i].exp_mwait));
      checkOutput($sformatf("row%0d mst_rdv", i), 32'(m_rdv), 32'(vecs[i].exp_mrdv));
      if (vecs[i].exp_gnt >= 0) begin
        checkOutput($sformatf("row%0d s_addr", i), s_addr, m_addr[vecs[i].exp_gnt]);
        checkOutput($sformatf("row%0d s_wdata", i), 32'(s_wdata), 32'(m_wdata[vecs[i].exp_gnt]));
        checkOutput($sformatf("row%0d s_be", i), 32'(s_be), 32'(m_be[vecs[i].exp_gnt]));
      end
      if (vecs[i].s_rdv) begin
        checkOutput($sformatf("row%0d m0_rdata", i), 32'(m_rdata[0]), 32'(vecs[i].s_rdata));
        checkOutput($sformatf("row%0d m1_rdata", i), 32'(m_rdata[1]), 32'(vecs[i].s_rdata));
      end
      nextCycle();
    end

    $display("[TB] queue full: master 0 issues nine reads");
    m_rd = 2'b01; m_wr = '0; s_wait = 1'b0; s_rdv = 1'b0; s_rdata = 16'h0000;
    accepted = 0;
    for (int c = 0; c < 40 && accepted < 8; c++) begin
      @(negedge clk);
      if (s_read && !s_wait) accepted++;
      nextCycle();
    end
    checkOutput("full accepted_reads", 32'(accepted), 32'd8);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("full stall%0d s_read", c), 32'(s_read), 32'd0);
      checkOutput($sformatf("full stall%0d m0_wait", c), 32'(m_wait[0]), 32'd1);
      nextCycle();
    end
    s_rdv = 1'b1; s_rdata = 16'h0F0F;
    @(negedge clk);
    checkOutput("full pop m_rdv", 32'(m_rdv), 32'h1);
    checkOutput("full pop s_read", 32'(s_read), 32'd0);
    checkOutput("full pop m0_wait", 32'(m_wait[0]), 32'd1);
    nextCycle();
    s_rdv = 1'b0;
    @(negedge clk);
    checkOutput("full release s_read", 32'(s_read), 32'd1);
    checkOutput("full release m0_wait", 32'(m_wait[0]), 32'd0);
    nextCycle();
    m_rd = 2'b00;
    for (int c = 0; c < 9; c++) begin
      s_rdv = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("drain%0d m_rdv", c), 32'(m_rdv), (c < 8) ? 32'h1 : 32'h0);
      nextCycle();
    end
    s_rdv = 1'b0;

    $display("[TB] slave wait states on master 1 write");
    m_wr = 2'b11; s_wait = 1'b1;
    @(negedge clk);
    checkOutput("ws idle m_wait", 32'(m_wait), 32'h3);
    checkOutput("ws idle s_write", 32'(s_write), 32'd0);
    nextCycle();
    for (int c = 1; c <= 6; c++) begin
      s_wait = (c < 6);
      @(negedge clk);
      checkOutput($sformatf("ws c%0d s_write", c), 32'(s_write), 32'd1);
      checkOutput($sformatf("ws c%0d s_addr", c), s_addr, 32'h0000_0080);
      checkOutput($sformatf("ws c%0d s_wdata", c), 32'(s_wdata), 32'hBEEF);
      checkOutput($sformatf("ws c%0d m_wait", c), 32'(m_wait), (c < 6) ? 32'h3 : 32'h1);
      nextCycle();
    end
    m_wr = 2'b01;
    @(negedge clk);
    checkOutput("ws next idle m_wait", 32'(m_wait), 32'h3);
    nextCycle();
    @(negedge clk);
    checkOutput("ws m0 s_write", 32'(s_write), 32'd1);
    checkOutput("ws m0 s_addr", s_addr, 32'h0000_0040);
    checkOutput("ws m0 m_wait", 32'(m_wait), 32'h2);
    nextCycle();
    m_wr = 2'b00;

    $display("[TB] reset with reads pending");
    m_rd = 2'b10;
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (s_read && !s_wait) accepted++;
      nextCycle();
    end
    checkOutput("rst pending_reads", 32'(accepted), 32'd3);
    m_rd = 2'b00;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rst hold%0d m_wait", c), 32'(m_wait), 32'h3);
      checkOutput($sformatf("rst hold%0d m_rdv", c), 32'(m_rdv), 32'h0);
      nextCycle();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      s_rdv = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("rst stray%0d m_rdv", c), 32'(m_rdv), 32'h0);
      nextCycle();
    end
    s_rdv = 1'b0;
    m_rd = 2'b11;
    nextCycle();
    @(negedge clk);
    checkOutput("rst first s_read", 32'(s_read), 32'd1);
    checkOutput("rst first s_addr", s_addr, 32'h0000_0040);
    checkOutput("rst first m_wait", 32'(m_wait), 32'h2);
    nextCycle();
    m_rd = 2'b00;
    repeat (2) nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/amm_arbiter.md
AMM_ARBITER -- requirements
Module: amm_arbiter

Interface
REQ-001 Parameter MST_CNT, default 2: number of upstream Avalon-MM masters.
REQ-002 Parameter MAX_PEND, default 8: maximum outstanding reads, a power of two.
REQ-003 Parameter ADDR_W, default 32; parameter DATA_W, default 16; both match avalon_mm_if #(32,16).
REQ-004 Port clk_i: input, 1 bit, single clock for all logic.
REQ-005 Port rst_i: input, 1 bit, asynchronous, active-low reset.
REQ-006 Port mst_mem_if[0:MST_CNT-1]: avalon_mm_if, slave side, one per upstream master.
REQ-007 Port slv_mem_if: avalon_mm_if, master side, towards the single downstream slave.
REQ-008 Each interface carries address, read, write, writedata, byteenable, readdata, readdatavalid and waitrequest.

Function
REQ-009 The FSM SHALL have two states: IDLE and GRANT.
REQ-010 In IDLE with any mst read|write asserted, the arbiter SHALL register grant_id and enter GRANT on the next edge.
- grant_id is the first requesting index after last_id, modulo MST_CNT (round-robin).
REQ-011 In IDLE, slv read and write SHALL be 0, and every mst waitrequest SHALL be 1.
REQ-012 In GRANT, slv address, writedata, byteenable, read and write SHALL equal the granted master's signals combinationally.
REQ-013 In GRANT, the granted master's waitrequest SHALL equal slv waitrequest; all other masters' waitrequest SHALL be 1.
REQ-014 A transfer is accepted when, in GRANT, (slv read|write) is 1 and slv waitrequest is 0.
- On acceptance: last_id <= grant_id, and the state returns to IDLE.
- Minimum cost is 2 cycles per transfer.
REQ-015 On acceptance of a read, grant_id SHALL be pushed into the pending-ID FIFO.
REQ-016 If the granted request is a read and the FIFO is full:
- slv read SHALL be held 0;
- the granted master's waitrequest SHALL be 1;
- the FSM SHALL stay in GRANT until a pop frees an entry.
- A push in the cycle after the freeing pop is legal.
REQ-017 Writes SHALL never be stalled by FIFO fullness.
REQ-018 slv readdata SHALL be broadcast to all masters.
REQ-019 slv readdatavalid SHALL assert readdatavalid only on the master at the FIFO head, in the same cycle (zero latency), and SHALL pop the FIFO.
REQ-020 Push and pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-021 slv readdatavalid with the FIFO empty SHALL be ignored: no pop and no master readdatavalid.
REQ-022 If the granted master drops read|write while in GRANT (protocol violation), the FSM SHALL return to IDLE with no transfer and no change to last_id.
REQ-023 After reset, last_id SHALL equal MST_CNT-1, so master 0 wins the first arbitration.
REQ-024 Simultaneous requests from all masters SHALL be served in order last_id+1, last_id+2, …, with each master granted exactly once per MST_CNT grants.

Reset
REQ-025 While rst_i is 0:
- state = IDLE; FIFO count, read and write pointers = 0;
- slv read and write = 0;
- all mst waitrequest = 1 and all mst readdatavalid = 0.
REQ-026 Reset asserted mid-transfer or with reads pending SHALL discard all pending IDs.
- Later slv readdatavalid pulses are then ignored per REQ-021.

Structure
REQ-027 Package amm_arb_pkg SHALL hold the state enum typedef and the function computing the ID width, $clog2(MST_CNT) with a minimum of 1.
REQ-028 The pending-ID store SHALL be a sub-module, amm_arb_fifo: synchronous, MAX_PEND deep, with full and empty flags, asynchronous active-low reset.
REQ-029 The block SHALL be placed between N masters and a single slave.
- A typical chain is amm_arbiter followed by amm_conv, then amm_demux.

Verification
REQ-030 Master 0 writes 0x1234 to address 0x40 while the slave has waitrequest 0 -> slave sees write with 0x1234 exactly 1 cycle after the request; mst0 waitrequest is 0 in that cycle only.
REQ-031 Both masters request reads continuously; the slave answers with readdatavalid 2 cycles later -> grants alternate 0,1,0,1, and each readdata returns only to its issuing master, in order.
REQ-032 MAX_PEND=8 and the slave withholds readdatavalid; master 0 issues 9 reads -> 8 are accepted, the 9th is stalled with waitrequest 1; one readdatavalid releases it on the following cycle.
REQ-033 Slave waitrequest is held 1 for 5 cycles during master 1's write -> all address and data are stable; master 0 sees waitrequest 1 throughout; the transfer is accepted in cycle 6.
REQ-034 rst_i is pulled to 0 with 3 reads pending, then released -> the FIFO is empty; 3 stray slave readdatavalid pulses produce no mst readdatavalid; the next grant goes to master 0.
